serial_sub: RTL and testbench

- Bit-serial ripple-borrow subtractor; the subtract-side counterpart of the 8-bit ripple-carry adder in the adders library.
- Computes Diff = A - B - Bin, producing one difference bit per clock, LSB first, through a single full-subtractor cell.
- Start/done handshake lets a sequencer or datapath controller issue operations and collect Diff, Bout and signed overflow V.
- Trades latency for area against a parallel subtractor.

---
 rtl/serial_sub.sv | 141 ++++++++++++++
 tb/tb_serial_sub.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_sub.sv
// serial_sub: bit-serial ripple-borrow subtractor.
// Computes Diff = A - B - Bin one bit per clock, LSB first, through a single
// full-subtractor cell. A start/done handshake brackets each operation. Diff,
// Bout and V are updated together at the completion edge and are held until
// the next completion edge.
module serial_sub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             V
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state, state_nxt;

  // Operand shift registers. Both shift right, so the current bit is at [0].
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  // Difference bits collected so far. Each new bit enters at the top, so after
  // WIDTH-1 steps d0 sits at bit 0. The final bit is appended combinationally.
  logic [WIDTH-2:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic             brw;
  logic [CW-1:0]    cnt;

  // FSM control strobes.
  logic load;
  logic step;
  logic last;

  // Full-subtractor cell outputs.
  logic a_k;
  logic b_k;
  logic d_bit;
  logic brw_nxt;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic and datapath strobes. A start is only looked at in IDLE,
  // which covers the done cycle, so back-to-back starts are accepted.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    last      = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST_BIT) begin
          last      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy = (state == RUN);

  // Single full-subtractor cell working on the current operand bits.
  always_comb begin
    a_k      = a_sh[0];
    b_k      = b_sh[0];
    d_bit    = a_k ^ b_k ^ brw;
    brw_nxt  = (~a_k & b_k) | (~(a_k ^ b_k) & brw);
    res_next = {d_bit, res_sh};
  end

  // Operand shift registers, borrow flop, bit counter and partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      a_sh   <= A;
      b_sh   <= B;
      brw    <= Bin;
      cnt    <= '0;
    end else if (step) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_next[WIDTH-1:1];
      brw    <= brw_nxt;
      cnt    <= cnt + CW'(1);
    end
  end

  // Result registers and done pulse, updated only at the completion edge.
  // At the last step a_k/b_k are the operand sign bits and d_bit is the result
  // sign bit, so overflow needs no extra storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Diff <= '0;
      Bout <= 1'b0;
      V    <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= last;
      if (last) begin
        Diff <= res_next;
        Bout <= brw_nxt;
        V    <= (a_k != b_k) & (d_bit != a_k);
      end
    end
  end

endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: scoreboard bench for serial_sub. Stimulus pushes expected
// results from an arithmetic reference model; a monitor pops them on done.
module tb_serial_sub;

  localparam int W = 8;
  localparam int NRAND = 3000;

  typedef struct packed {
    logic [W-1:0] diff;
    logic         bout;
    logic         v;
  } res_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         Bin;
  logic         busy;
  logic         done;
  logic [W-1:0] Diff;
  logic         Bout;
  logic         V;

  int   total;
  int   bad;
  int   acceptedCount;
  int   doneCount;
  res_t expQ[$];
  res_t held;

  serial_sub #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .A    (A),
    .B    (B),
    .Bin  (Bin),
    .busy (busy),
    .done (done),
    .Diff (Diff),
    .Bout (Bout),
    .V    (V)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: plain integer arithmetic on unsigned and signed views.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic bin);
    res_t r;
    int   ud;
    int   sd;
    ud     = int'(a) - int'(b) - int'(bin);
    sd     = int'($signed(a)) - int'($signed(b)) - int'(bin);
    r.diff = W'(ud + (1 << W));
    r.bout = (ud < 0);
    r.v    = (sd > (1 << (W - 1)) - 1) || (sd < -(1 << (W - 1)));
    return r;
  endfunction

  // One comparison: count it, report it on mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Wait (bounded) until the DUT can accept a start.
  task automatic waitIdle();
    int n;
    n = 0;
    while (busy === 1'b1 && n < 8 * W) begin
      tick(1);
      n++;
    end
    if (busy !== 1'b0) checkOutput("idle timeout", 32'(busy), 32'd0);
  endtask

  // Issue one operation and record its expected result.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic bin);
    waitIdle();
    start = 1'b1;
    A     = a;
    B     = b;
    Bin   = bin;
    expQ.push_back(model(a, b, bin));
    acceptedCount++;
    tick(1);
    start = 1'b0;
    A     = W'($urandom);
    B     = W'($urandom);
    Bin   = 1'($urandom);
  endtask

  // Monitor: pop on done, otherwise results must hold their last value.
  always @(negedge clk) begin
    if (!rst_n) begin
      held <= '0;
    end else if (done) begin
      doneCount++;
      if (expQ.size() == 0) begin
        checkOutput("unexpected done", 32'(done), 32'd0);
      end else begin
        res_t e;
        e = expQ.pop_front();
        checkOutput("result", 32'({Diff, Bout, V}), 32'(e));
        held <= e;
      end
    end else begin
      checkOutput("hold", 32'({Diff, Bout, V}), 32'(held));
    end
  end

  initial begin
    int doneSnap;
    int gap;
    total         = 0;
    bad           = 0;
    acceptedCount = 0;
    doneCount     = 0;
    rst_n         = 1'b0;
    start         = 1'b0;
    A             = '0;
    B             = '0;
    Bin           = 1'b0;

    // Reset values.
    tick(3);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset result", 32'({Diff, Bout, V}), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Latency and busy window: 5 - 3.
    applyStimulus(8'h05, 8'h03, 1'b0);
    for (int k = 1; k <= W; k++) begin
      checkOutput("busy in run", 32'(busy), 32'd1);
      checkOutput("no early done", 32'(done), 32'd0);
      tick(1);
    end
    checkOutput("done at latency", 32'(done), 32'd1);
    checkOutput("busy low at done", 32'(busy), 32'd0);
    checkOutput("diff 5-3", 32'(Diff), 32'h02);
    tick(1);
    checkOutput("done one cycle", 32'(done), 32'd0);

    // Borrow and overflow corners.
    applyStimulus(8'h00, 8'h01, 1'b0);
    applyStimulus(8'h10, 8'h10, 1'b1);
    applyStimulus(8'h80, 8'h01, 1'b0);
    applyStimulus(8'h7F, 8'hFF, 1'b0);
    waitIdle();
    tick(1);

    // Start while busy is ignored; new start in the done cycle is accepted.
    applyStimulus(8'h40, 8'h20, 1'b0);
    tick(2);
    start = 1'b1;
    A     = 8'hFF;
    B     = 8'hFF;
    tick(1);
    start = 1'b0;
    applyStimulus(8'h01, 8'h02, 1'b0);
    tick(3);
    checkOutput("diff held while busy", 32'(Diff), 32'h20);
    waitIdle();
    checkOutput("back-to-back diff", 32'(Diff), 32'hFF);
    checkOutput("back-to-back bout", 32'(Bout), 32'd1);
    tick(1);

    // Reset during RUN aborts the operation.
    applyStimulus(8'h55, 8'h11, 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort done", 32'(done), 32'd0);
    checkOutput("abort result", 32'({Diff, Bout, V}), 32'd0);
    void'(expQ.pop_back());
    acceptedCount--;
    tick(2);
    rst_n    = 1'b1;
    doneSnap = doneCount;
    tick(W + 3);
    checkOutput("no done after abort", 32'(doneCount - doneSnap), 32'd0);
    applyStimulus(8'h55, 8'h11, 1'b0);
    waitIdle();
    checkOutput("post-reset diff", 32'(Diff), 32'h44);
    checkOutput("post-reset bout", 32'(Bout), 32'd0);
    tick(1);

    // Random regression with mixed back-to-back starts and idle gaps.
    for (int i = 0; i < NRAND; i++) begin
      gap = $urandom_range(0, 3);
      if (gap > 1) begin
        waitIdle();
        tick(gap - 1);
      end
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom));
    end
    waitIdle();
    tick(2);

    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    checkOutput("done count", 32'(doneCount), 32'(acceptedCount));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
